// File: rtl/mem_io_resp_pkg.sv
// Shared constants for the memory/IO response block: IO window decode,
// register offsets and status bit positions.
package mem_io_resp_pkg;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [15:0] IO_DATA = 16'h0000;
    localparam logic [15:0] IO_STAT = 16'h0004;

    // status byte layout: {4'b0, rx_ovr, tx_ovr, tx_full, rx_nonempty}
    localparam int STAT_RX_NE   = 0;
    localparam int STAT_TX_FULL = 1;
    localparam int STAT_TX_OVR  = 2;
    localparam int STAT_RX_OVR  = 3;

    // one CPU-side byte access, decoded bits only
    typedef struct packed {
        logic        wr;
        logic [17:0] addr;
        logic [7:0]  data;
    } cpu_req_t;

    // IO space is the top quarter of the 18-bit decoded window
    function automatic logic is_io(input logic [17:0] a);
        return a[17:16] == IO_BASE[17:16];
    endfunction

endpackage

// File: rtl/mem_io_resp_if.sv
// Bus bundle between the memory controller / UART side and mem_io_resp.
// The rx strobe pair only exists when IO_RX_EN is defined.
interface mem_io_resp_if;
    logic        cpu_wr;
    logic [31:0] ram_addr_i;
    logic [7:0]  cpu_data_i;
    logic [7:0]  din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`ifdef IO_RX_EN
    logic [7:0]  rx_data;
    logic        rx_valid;
`endif

    modport master (
        output cpu_wr, ram_addr_i, cpu_data_i, tx_ready,
`ifdef IO_RX_EN
        output rx_data, rx_valid,
`endif
        input  din, tx_data, tx_valid
    );

    modport slave (
        input  cpu_wr, ram_addr_i, cpu_data_i, tx_ready,
`ifdef IO_RX_EN
        input  rx_data, rx_valid,
`endif
        output din, tx_data, tx_valid
    );
endinterface

// File: rtl/mem_io_resp_byte_fifo.sv
// byte_fifo: small power-of-two byte FIFO. A push while full is accepted
// only if a pop happens in the same cycle; otherwise it is dropped and
// flagged on 'drop' for one cycle. Popping an empty FIFO does nothing and
// rdata reads 0 while empty.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    slot_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // accept/drop decision and pointer/count update; pointers wrap naturally
    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        count    = cnt_q;
        rdata    = empty ? 8'h00 : slot_q[rd_ptr_q];
    end

    // pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // storage is not reset; stale bytes are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (do_push) slot_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/mem_io_resp.sv
// mem_io_resp: byte RAM plus a tiny memory-mapped UART/halt IO window.
// Reads return one cycle later on din. 0x30000 is the data port (tx push on
// write, rx pop on read), 0x30004 is status on read and halt on write.
// Optional rx path: define IO_RX_EN to build the rx FIFO and rx ports.
module mem_io_resp
    import mem_io_resp_pkg::*;
#(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy_in,
    mem_io_resp_if.slave  bus,
    output logic          halt
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    cpu_req_t          req;
    logic              io_sel, hit_data, hit_stat, rd_data;
    logic              push_tx, set_halt, ram_we;
    logic [RAM_AW-1:0] ram_idx;

    // decode the access and gate every side effect with rdy_in
    always_comb begin
        req      = '{wr: bus.cpu_wr, addr: bus.ram_addr_i[17:0], data: bus.cpu_data_i};
        io_sel   = is_io(req.addr);
        hit_data = io_sel && (req.addr[15:0] == IO_DATA);
        hit_stat = io_sel && (req.addr[15:0] == IO_STAT);
        rd_data  = !req.wr && hit_data;
        push_tx  = req.wr && hit_data && rdy_in;
        set_halt = req.wr && hit_stat && rdy_in;
        ram_we   = req.wr && !io_sel && rdy_in;
        ram_idx  = bus.ram_addr_i[RAM_AW-1:0];
    end

    logic [7:0] ram_q [2**RAM_AW];
    logic [7:0] ram_rd_q;

    // RAM array: read-first synchronous port, contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= req.data;
        ram_rd_q <= ram_q[ram_idx];
    end

    logic             tx_full, tx_empty, tx_drop, tx_pop;
    logic [TX_CW-1:0] tx_cnt;
    logic [7:0]       tx_head;

    assign tx_pop = !tx_empty && bus.tx_ready;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk, .rst,
        .push (push_tx),
        .wdata(req.data),
        .pop  (tx_pop),
        .rdata(tx_head),
        .full (tx_full),
        .empty(tx_empty),
        .count(tx_cnt),
        .drop (tx_drop)
    );

    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_head;

    logic       rd_data_prev_q, rd_data_prev_d;
    logic       rx_ne, rx_drop;
    logic [7:0] rx_head;
    logic       unused_rx;

`ifdef IO_RX_EN
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    logic             rx_pop, rx_full, rx_empty;
    logic [RX_CW-1:0] rx_cnt;

    // one pop per access: only the first cycle of a held data-port read pops
    assign rx_pop = rd_data && !rd_data_prev_q && rdy_in;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk, .rst,
        .push (bus.rx_valid),
        .wdata(bus.rx_data),
        .pop  (rx_pop),
        .rdata(rx_head),
        .full (rx_full),
        .empty(rx_empty),
        .count(rx_cnt),
        .drop (rx_drop)
    );

    assign rx_ne     = !rx_empty;
    assign unused_rx = ^{rx_cnt, rx_full};
`else
    assign rx_head   = 8'h00;
    assign rx_ne     = 1'b0;
    assign rx_drop   = 1'b0;
    assign unused_rx = ^{RX_DEPTH};
`endif

    logic       tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d, halt_q, halt_d;
    logic       io_sel_q, io_sel_d, rd_vld_q, rd_vld_d;
    logic [7:0] io_rd_q, io_rd_d, status;

    // sticky flags and the IO read value; a held data read repeats its byte
    always_comb begin
        tx_ovr_d       = tx_ovr_q | tx_drop;
        rx_ovr_d       = rx_ovr_q | rx_drop;
        halt_d         = halt_q | set_halt;
        rd_data_prev_d = rd_data;
        io_sel_d       = io_sel;
        rd_vld_d       = 1'b1;
        status                = 8'h00;
        status[STAT_RX_NE]    = rx_ne;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_OVR]   = tx_ovr_q;
        status[STAT_RX_OVR]   = rx_ovr_q;
        io_rd_d = 8'h00;
        if (hit_data)      io_rd_d = (rd_data && rd_data_prev_q) ? io_rd_q : rx_head;
        else if (hit_stat) io_rd_d = status;
    end

    // control registers; reset also voids any read result in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovr_q       <= 1'b0;
            rx_ovr_q       <= 1'b0;
            halt_q         <= 1'b0;
            rd_data_prev_q <= 1'b0;
            io_sel_q       <= 1'b0;
            rd_vld_q       <= 1'b0;
            io_rd_q        <= 8'h00;
        end else begin
            tx_ovr_q       <= tx_ovr_d;
            rx_ovr_q       <= rx_ovr_d;
            halt_q         <= halt_d;
            rd_data_prev_q <= rd_data_prev_d;
            io_sel_q       <= io_sel_d;
            rd_vld_q       <= rd_vld_d;
            io_rd_q        <= io_rd_d;
        end
    end

    assign bus.din = !rd_vld_q ? 8'h00 : (io_sel_q ? io_rd_q : ram_rd_q);
    assign halt    = halt_q;

    logic unused_bits;
    assign unused_bits = ^{bus.ram_addr_i[31:18], tx_cnt, unused_rx};
endmodule

// File: tb/tb_mem_io_resp.sv
// Randomized + directed bench for mem_io_resp with a queue-based model.
module tb_mem_io_resp;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk = 1'b0;
    logic        rst, rdy_v, wr_v, txr_v, halt;
    logic [31:0] addr_v;
    logic [7:0]  wdata_v;
`ifdef IO_RX_EN
    logic        rxv_v;
    logic [7:0]  rxd_v;
`endif

    int nchk = 0;
    int nbad = 0;

    mem_io_resp_if bus();
    assign bus.cpu_wr     = wr_v;
    assign bus.ram_addr_i = addr_v;
    assign bus.cpu_data_i = wdata_v;
    assign bus.tx_ready   = txr_v;
`ifdef IO_RX_EN
    assign bus.rx_valid   = rxv_v;
    assign bus.rx_data    = rxd_v;
`endif

    mem_io_resp #(.RAM_AW(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_v), .bus(bus), .halt(halt)
    );

    always #5 clk = ~clk;

    // reference state
    logic [7:0] mem_m [int];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    bit         m_prev, m_txovr, m_rxovr, m_halt, m_known;
    logic [7:0] m_din, m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // apply one clock edge of the specified behaviour to the model
    task automatic model_edge();
        logic [17:0] a;
        logic        io, dat, st, rd, txpop, txfull;
        logic [7:0]  e;
        bit          known;
        int          key;
        a   = addr_v[17:0];
        key = int'(a[16:0]);
        io  = (a[17:16] == 2'b11);
        dat = io && (a[15:0] == 16'h0000);
        st  = io && (a[15:0] == 16'h0004);
        rd  = !wr_v;
        known = 1'b1;
        e     = 8'h00;
        if (!io) begin
            if (mem_m.exists(key)) e = mem_m[key];
            else known = 1'b0;
        end else if (dat) begin
            e = (rd && m_prev) ? m_last : ((rxq.size() != 0) ? rxq[0] : 8'h00);
        end else if (st) begin
            e = {4'b0, m_rxovr, m_txovr, txq.size() == TXD, rxq.size() != 0};
        end
        if (wr_v && !io && rdy_v) mem_m[key] = wdata_v;
        if (rst) begin
            txq.delete(); rxq.delete();
            m_prev = 0; m_txovr = 0; m_rxovr = 0; m_halt = 0;
            m_din = 8'h00; m_last = 8'h00; m_known = 1;
            return;
        end
        txfull = (txq.size() == TXD);
        txpop  = (txq.size() != 0) && txr_v;
        if (txpop) void'(txq.pop_front());
        if (wr_v && dat && rdy_v) begin
            if (!txfull || txpop) txq.push_back(wdata_v);
            else m_txovr = 1;
        end
`ifdef IO_RX_EN
        begin
            logic rxfull, rxpop;
            rxfull = (rxq.size() == RXD);
            rxpop  = rd && dat && !m_prev && rdy_v && (rxq.size() != 0);
            if (rxpop) void'(rxq.pop_front());
            if (rxv_v) begin
                if (!rxfull || rxpop) rxq.push_back(rxd_v);
                else m_rxovr = 1;
            end
        end
`endif
        if (wr_v && st && rdy_v) m_halt = 1;
        m_prev  = rd && dat;
        m_last  = e;
        m_din   = e;
        m_known = known;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (m_known) chk("din", bus.din, m_din);
        chk("tx_valid", bus.tx_valid, txq.size() != 0);
        chk("tx_data", bus.tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
        chk("halt", halt, m_halt);
    endtask

    task automatic set(input logic w, input logic [31:0] a, input logic [7:0] d);
        wr_v = w; addr_v = a; wdata_v = d;
    endtask

    initial begin
        rst = 1; rdy_v = 1; txr_v = 0;
        set(0, 32'h0, 8'h00);
`ifdef IO_RX_EN
        rxv_v = 0; rxd_v = 8'h00;
`endif
        m_known = 0;
        tick(); tick();
        chk("rst_din", bus.din, 8'h00);
        chk("rst_txv", bus.tx_valid, 1'b0);
        chk("rst_txd", bus.tx_data, 8'h00);
        chk("rst_halt", halt, 1'b0);
        rst = 0;
        set(0, 32'h30004, 8'h00); tick();
        chk("rst_stat", bus.din, 8'h00);

        // RAM write then read-back, and a write suppressed by rdy_in
        set(1, 32'h100, 8'hA5); tick();
        set(0, 32'h100, 8'h00); tick();
        chk("ram_rw", bus.din, 8'hA5);
        rdy_v = 0; set(1, 32'h100, 8'h11); tick();
        rdy_v = 1; set(0, 32'h100, 8'h00); tick();
        chk("ram_rdy0", bus.din, 8'hA5);

        // tx fill past capacity
        for (int i = 0; i < 9; i++) begin
            set(1, 32'h30000, 8'(8'h40 + i)); tick();
        end
        chk("tx_head", bus.tx_data, 8'h40);
        set(0, 32'h30004, 8'h00); tick();
        chk("tx_ovf_stat", bus.din, 8'h06);

        // push into full FIFO while draining
        txr_v = 1; set(1, 32'h30000, 8'h50); tick();
        txr_v = 0; set(0, 32'h30004, 8'h00); tick();
        chk("tx_full_kept", bus.din, 8'h06);
        txr_v = 1; set(0, 32'h0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk("tx_order", bus.tx_data, (i < 7) ? 8'(8'h41 + i) : 8'h50);
            tick();
        end
        chk("tx_drained", bus.tx_valid, 1'b0);

        // halt needs rdy_in
        rdy_v = 0; set(1, 32'h30004, 8'h00); tick();
        chk("halt_rdy0", halt, 1'b0);
        rdy_v = 1; tick();
        chk("halt_set", halt, 1'b1);
        set(0, 32'h0, 8'h00); tick(); tick();
        chk("halt_sticky", halt, 1'b1);

        // reset in the middle of a drain
        txr_v = 0;
        for (int i = 0; i < 3; i++) begin
            set(1, 32'h30000, 8'(8'h60 + i)); tick();
        end
        set(0, 32'h0, 8'h00); txr_v = 1; tick();
        rst = 1; tick();
        chk("rst_mid_txv", bus.tx_valid, 1'b0);
        chk("rst_mid_halt", halt, 1'b0);
        rst = 0; txr_v = 0; set(0, 32'h30004, 8'h00); tick();
        chk("rst_mid_stat", bus.din, 8'h00);

`ifdef IO_RX_EN
        rxv_v = 1; rxd_v = 8'h31; tick();
        rxd_v = 8'h32; tick();
        rxv_v = 0;
        set(0, 32'h30000, 8'h00);
        repeat (3) begin
            tick();
            chk("rx_hold", bus.din, 8'h31);
        end
        set(0, 32'h0, 8'h00); tick();
        set(0, 32'h30000, 8'h00); tick();
        chk("rx_next", bus.din, 8'h32);
        set(0, 32'h0, 8'h00); tick();
        set(0, 32'h30000, 8'h00); tick();
        chk("rx_empty", bus.din, 8'h00);
        set(0, 32'h30004, 8'h00); tick();
        chk("rx_stat0", bus.din, 8'h00);
        rxv_v = 1;
        for (int i = 0; i < 9; i++) begin
            rxd_v = 8'(8'h70 + i); tick();
        end
        rxv_v = 0; tick();
        chk("rx_ovf_stat", bus.din, 8'h09);
`else
        set(0, 32'h30000, 8'h00); tick();
        chk("rx_off", bus.din, 8'h00);
`endif

        // randomized traffic against the model
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 7))
                    0, 1, 2: addr_v = 32'h200 + 32'($urandom_range(0, 7));
                    3:       addr_v = 32'h20200 + 32'($urandom_range(0, 7));
                    4, 5:    addr_v = {14'($urandom), 18'h30000};
                    6:       addr_v = 32'h30004;
                    default: addr_v = 32'h30008 + 32'($urandom_range(0, 15) * 4);
                endcase
            end
            wr_v    = ($urandom_range(0, 99) < 30);
            wdata_v = 8'($urandom);
            rdy_v   = ($urandom_range(0, 99) < 85);
            txr_v   = ($urandom_range(0, 1) == 1);
            rst     = ($urandom_range(0, 199) == 0);
`ifdef IO_RX_EN
            rxv_v   = ($urandom_range(0, 99) < 30);
            rxd_v   = 8'($urandom);
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
